// File: rtl/phrase_sequencer_if.sv
// Phrase RAM read port between the sequencer and the synchronous phrase RAM.
//   rd_en  : read strobe; the RAM returns data the cycle after it is seen high
//   addr   : {phrase, line[3:0], ch[1:0]}
//   rdata  : 16-bit channel entry from the RAM
// The master modport is the sequencer side; the slave modport is the RAM side.
interface phrase_sequencer_if #(
  parameter int PHRASE_W = 4
);
  logic                  rd_en;
  logic [PHRASE_W+5:0]   addr;
  logic [15:0]           rdata;

  modport master (output rd_en, output addr, input rdata);
  modport slave  (input rd_en, input addr, output rdata);
endinterface

// File: rtl/phrase_sequencer.sv
// Song-level controller for the 4-channel playback datapath.
// A tempo accumulator produces a line tick on the carry out of acc+inc. On each
// line the four channel entries are read from phrase RAM into shadow registers
// and then presented together on current_entry. Phrases start_phrase..end_phrase
// are stepped in order (modulo 2**PHRASE_W), then playback loops or stops.
// Ports:
//   clk, reset_active_low : clock and asynchronous active-low reset
//   play, stop            : 1-cycle control pulses (stop wins)
//   loop_enable           : wrap to start_phrase after end_phrase, else finish
//   tempo                 : BPM, sampled every cycle; 0 freezes the accumulator
//   start_phrase/end_phrase : phrase range, sampled at the phrase boundary
//   mem                   : phrase RAM read port (master side)
//   current_entry[0:3]    : presented entries {note, volume, instrument}
//   line_count/phrase_count : position currently presented
//   line_strobe           : pulse on the cycle current_entry changes
//   playing, done         : status; done pulses when a non-looping song ends
module phrase_sequencer #(
  parameter int                   ACC_WIDTH   = 48,
  parameter logic [ACC_WIDTH-1:0] TEMPO_SCALE = ACC_WIDTH'(46912),
  parameter int                   NUM_LINES   = 16,
  parameter int                   PHRASE_W    = 4
) (
  input  logic                 clk,
  input  logic                 reset_active_low,
  input  logic                 play,
  input  logic                 stop,
  input  logic                 loop_enable,
  input  logic [8:0]           tempo,
  input  logic [PHRASE_W-1:0]  start_phrase,
  input  logic [PHRASE_W-1:0]  end_phrase,
  phrase_sequencer_if.master   mem,
  output logic [0:3][15:0]     current_entry,
  output logic [3:0]           line_count,
  output logic [PHRASE_W-1:0]  phrase_count,
  output logic                 line_strobe,
  output logic                 playing,
  output logic                 done
);

  localparam logic [15:0] SILENCE   = 16'hFF00;
  localparam logic [3:0]  LAST_LINE = 4'(NUM_LINES - 1);

  typedef enum logic [1:0] {IDLE, FETCH, COMMIT, RUN} state_t;

  state_t                state;
  logic [ACC_WIDTH-1:0]  acc;
  logic                  pending;      // carry seen while not in RUN
  logic [PHRASE_W-1:0]   fetch_phrase; // position being fetched
  logic [3:0]            fetch_line;
  logic [1:0]            fetch_ch;
  logic                  mem_rd_en;
  logic                  rd_d1;        // mem.rdata is valid this cycle
  logic [1:0]            rd_ch_d1;     // channel that rdata belongs to
  logic [0:3][15:0]      shadow;

  // Tempo increment and carry out of the accumulator.
  logic [ACC_WIDTH-1:0]  inc;
  logic [ACC_WIDTH:0]    acc_sum;
  logic                  carry;

  assign inc     = ACC_WIDTH'(tempo) * TEMPO_SCALE;
  assign acc_sum = {1'b0, acc} + {1'b0, inc};
  assign carry   = acc_sum[ACC_WIDTH];

  assign mem.rd_en = mem_rd_en;
  assign mem.addr  = {fetch_phrase, fetch_line, fetch_ch};

  // Next line position; loop_enable/start/end only matter at line 15.
  logic [3:0]          next_line;
  logic [PHRASE_W-1:0] next_phrase;
  logic                song_end;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    next_line   = fetch_line + 4'd1;
    next_phrase = fetch_phrase;
    song_end    = 1'b0;
    if (fetch_line == LAST_LINE) begin
      next_line = 4'd0;
      if (fetch_phrase != end_phrase)
        next_phrase = fetch_phrase + 1'b1;
      else if (loop_enable)
        next_phrase = start_phrase;
      else
        song_end = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values and the last assignment in program order
  // wins (used below for the per-cycle strobe defaults).
  always_ff @(posedge clk or negedge reset_active_low) begin
    if (!reset_active_low) begin
      state         <= IDLE;
      acc           <= '0;
      pending       <= 1'b0;
      fetch_phrase  <= '0;
      fetch_line    <= '0;
      fetch_ch      <= '0;
      mem_rd_en     <= 1'b0;
      rd_d1         <= 1'b0;
      rd_ch_d1      <= '0;
      // NOTE: the shadow bank is four flops, not a RAM, so it is reset like
      // any other register; it is fully rewritten before each commit anyway.
      shadow        <= {4{SILENCE}};
      current_entry <= {4{SILENCE}};
      line_count    <= '0;
      phrase_count  <= '0;
      line_strobe   <= 1'b0;
      playing       <= 1'b0;
      done          <= 1'b0;
    end else begin
      line_strobe <= 1'b0;
      done        <= 1'b0;
      rd_d1       <= mem_rd_en;
      rd_ch_d1    <= fetch_ch;

      if (stop) begin
        state         <= IDLE;
        acc           <= '0;
        pending       <= 1'b0;
        mem_rd_en     <= 1'b0;
        rd_d1         <= 1'b0;
        current_entry <= {4{SILENCE}};
        playing       <= 1'b0;
      end else if (play) begin
        // Restart from any state; an in-flight read is dropped by clearing rd_d1.
        state        <= FETCH;
        acc          <= '0;
        pending      <= 1'b0;
        fetch_phrase <= start_phrase;
        fetch_line   <= 4'd0;
        fetch_ch     <= 2'd0;
        mem_rd_en    <= 1'b1;
        rd_d1        <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            acc <= '0;
          end

          FETCH: begin
            acc <= acc_sum[ACC_WIDTH-1:0];
            if (carry) pending <= 1'b1;
            // Issue side: channels 0..3 on consecutive cycles.
            if (mem_rd_en) begin
              if (fetch_ch == 2'd3) mem_rd_en <= 1'b0;
              else                  fetch_ch  <= fetch_ch + 2'd1;
            end
            // Capture side: one cycle behind the issue side.
            if (rd_d1) begin
              shadow[rd_ch_d1] <= mem.rdata;
              if (rd_ch_d1 == 2'd3) state <= COMMIT;
            end
          end

          COMMIT: begin
            acc <= acc_sum[ACC_WIDTH-1:0];
            if (carry) pending <= 1'b1;
            current_entry <= shadow;
            line_count    <= fetch_line;
            phrase_count  <= fetch_phrase;
            line_strobe   <= 1'b1;
            playing       <= 1'b1;
            state         <= RUN;
          end

          RUN: begin
            acc <= acc_sum[ACC_WIDTH-1:0];
            if (carry || pending) begin
              pending <= 1'b0;
              if (song_end) begin
                done          <= 1'b1;
                current_entry <= {4{SILENCE}};
                playing       <= 1'b0;
                acc           <= '0;
                state         <= IDLE;
              end else begin
                fetch_line   <= next_line;
                fetch_phrase <= next_phrase;
                fetch_ch     <= 2'd0;
                mem_rd_en    <= 1'b1;
                state        <= FETCH;
              end
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_phrase_sequencer.sv
// Self-checking bench for phrase_sequencer. A behavioural phrase RAM returns
// entry == address. TEMPO_SCALE is 2**40 so tempo=1 gives one line per 256
// cycles and tempo=16 one line per 16 cycles.
module tb_phrase_sequencer;
  localparam int          PHRASE_W = 4;
  localparam int          ACC_W    = 48;
  localparam logic [47:0] TSCALE   = 48'h0100_0000_0000; // 2**40
  localparam logic [15:0] SIL      = 16'hFF00;

  logic                clk = 1'b0;
  logic                reset_active_low = 1'b0;
  logic                play = 1'b0, stop = 1'b0, loop_enable = 1'b0;
  logic [8:0]          tempo = 9'd1;
  logic [PHRASE_W-1:0] start_phrase = '0, end_phrase = '0;
  logic [0:3][15:0]    current_entry;
  logic [3:0]          line_count;
  logic [PHRASE_W-1:0] phrase_count;
  logic                line_strobe, playing, done;

  phrase_sequencer_if #(.PHRASE_W(PHRASE_W)) bus ();

  phrase_sequencer #(
    .ACC_WIDTH(ACC_W), .TEMPO_SCALE(TSCALE), .NUM_LINES(16), .PHRASE_W(PHRASE_W)
  ) dut (
    .clk(clk), .reset_active_low(reset_active_low), .play(play), .stop(stop),
    .loop_enable(loop_enable), .tempo(tempo), .start_phrase(start_phrase),
    .end_phrase(end_phrase), .mem(bus.master), .current_entry(current_entry),
    .line_count(line_count), .phrase_count(phrase_count), .line_strobe(line_strobe),
    .playing(playing), .done(done)
  );

  always #5 clk = ~clk;

  // Synchronous phrase RAM whose content equals its address.
  always @(posedge clk) if (bus.rd_en) bus.rdata <= 16'(bus.addr);

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int done_cnt = 0;
  always @(negedge clk) if (done) done_cnt <= done_cnt + 1;

  int n_cmp = 0, n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Pulse play for one edge; returns at the negedge after the sampling edge.
  task automatic play_pulse(output int t_play);
    @(negedge clk); play = 1'b1;
    @(negedge clk); play = 1'b0;
    t_play = cyc;
  endtask

  task automatic wait_strobe(input int budget, output int t, output logic ok);
    ok = 1'b0; t = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (line_strobe) begin ok = 1'b1; t = cyc; return; end
    end
  endtask

  task automatic count_strobes(input int ncyc, output int n);
    n = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (line_strobe) n++;
    end
  endtask

  function automatic logic [15:0] ent(input int ph, input int ln, input int ch);
    return 16'((ph << 6) | (ln << 2) | ch);
  endfunction

  typedef struct {
    logic [3:0] sp;
    logic [3:0] ep;
    logic       lp;
    int         nlines;
    logic       exp_done;
  } vec_t;

  vec_t vecs [4];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   tp, t1, t2, t3, n, nphr, ph, ln, k;
    logic ok, seen;

    vecs[0] = '{sp: 4'd2,  ep: 4'd3, lp: 1'b0, nlines: 32, exp_done: 1'b1};
    vecs[1] = '{sp: 4'd2,  ep: 4'd3, lp: 1'b1, nlines: 34, exp_done: 1'b0};
    vecs[2] = '{sp: 4'd5,  ep: 4'd5, lp: 1'b0, nlines: 16, exp_done: 1'b1};
    vecs[3] = '{sp: 4'd14, ep: 4'd1, lp: 1'b0, nlines: 64, exp_done: 1'b1};

    // ---- reset state
    repeat (3) @(negedge clk);
    check("reset entries", 64'(current_entry), {4{SIL}});
    check("reset rd_en", 64'(bus.rd_en), 64'd0);
    check("reset status", {line_strobe, playing, done, line_count, phrase_count}, 64'd0);
    reset_active_low = 1'b1;

    // ---- tempo=1: latency, address order, line period
    tempo = 9'd1; start_phrase = 4'd0; end_phrase = 4'd0; loop_enable = 1'b1;
    play_pulse(tp);
    for (int c = 0; c < 4; c++) begin
      check($sformatf("fetch rd_en ch%0d", c), 64'(bus.rd_en), 64'd1);
      check($sformatf("fetch addr ch%0d", c), 64'(bus.addr), 64'(c));
      @(negedge clk);
    end
    check("fetch rd_en off", 64'(bus.rd_en), 64'd0);
    wait_strobe(20, t1, ok);
    check("first strobe seen", 64'(ok), 64'd1);
    check("first strobe latency", 64'(t1 - tp), 64'd6);
    check("line0 entries", 64'(current_entry), {ent(0,0,0), ent(0,0,1), ent(0,0,2), ent(0,0,3)});
    check("line0 pos/playing", {playing, line_count, phrase_count}, {1'b1, 4'd0, 4'd0});
    wait_strobe(300, t2, ok);
    check("line period", 64'(t2 - t1), 64'd256);
    check("line1 entry2", 64'(current_entry[2]), 64'(ent(0,1,2)));

    // ---- tempo=0 freeze for 1000 cycles, then resume from the held acc
    tempo = 9'd0;
    count_strobes(1000, n);
    check("no strobe while frozen", 64'(n), 64'd0);
    tempo = 9'd1;
    wait_strobe(400, t3, ok);
    check("resume timing", 64'(t3 - t2), 64'd1256);
    check("resume line", 64'(line_count), 64'd2);

    // ---- stop during FETCH (play restarts first)
    play_pulse(tp);
    stop = 1'b1;
    @(negedge clk); stop = 1'b0;
    check("stop rd_en", 64'(bus.rd_en), 64'd0);
    check("stop silence", 64'(current_entry), {4{SIL}});
    check("stop playing", 64'(playing), 64'd0);
    count_strobes(30, n);
    check("stop no strobe", 64'(n), 64'd0);

    // ---- play+stop in the same cycle while playing
    play_pulse(tp);
    wait_strobe(20, t1, ok);
    check("replay playing", 64'(playing), 64'd1);
    @(negedge clk); play = 1'b1; stop = 1'b1;
    @(negedge clk); play = 1'b0; stop = 1'b0;
    check("play+stop rd_en", 64'(bus.rd_en), 64'd0);
    check("play+stop silence", 64'(current_entry), {4{SIL}});
    check("play+stop playing", 64'(playing), 64'd0);
    count_strobes(30, n);
    check("play+stop no strobe", 64'(n), 64'd0);

    // ---- table-driven phrase ranges at tempo=16
    tempo = 9'd16;
    foreach (vecs[v]) begin
      int base;
      start_phrase = vecs[v].sp; end_phrase = vecs[v].ep; loop_enable = vecs[v].lp;
      nphr = ((int'(vecs[v].ep) - int'(vecs[v].sp)) & 15) + 1;
      base = done_cnt;
      play_pulse(tp);
      for (k = 0; k < vecs[v].nlines; k++) begin
        wait_strobe(64, t1, ok);
        if (!ok) begin
          check($sformatf("v%0d strobe %0d timeout", v, k), 64'd0, 64'd1);
          break;
        end
        ph = (int'(vecs[v].sp) + (k / 16) % nphr) % 16;
        ln = k % 16;
        check($sformatf("v%0d line %0d", v, k),
              {phrase_count, line_count, current_entry[0], current_entry[3]},
              {4'(ph), 4'(ln), ent(ph, ln, 0), ent(ph, ln, 3)});
      end
      if (vecs[v].exp_done) begin
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
          @(negedge clk);
          if (done) seen = 1'b1;
        end
        check($sformatf("v%0d done pulse", v), 64'(seen), 64'd1);
        check($sformatf("v%0d end silence", v), {63'(current_entry), playing}, {63'({4{SIL}}), 1'b0});
        @(negedge clk);
        check($sformatf("v%0d done one cycle", v), 64'(done), 64'd0);
      end else begin
        check($sformatf("v%0d no done", v), 64'(done_cnt - base), 64'd0);
      end
    end

    // ---- asynchronous reset mid-FETCH (line_count is 15 from the last range)
    play_pulse(tp);
    #2 reset_active_low = 1'b0;
    #1;
    check("async rst rd_en", 64'(bus.rd_en), 64'd0);
    check("async rst entries", 64'(current_entry), {4{SIL}});
    check("async rst counts", {playing, line_count, phrase_count}, 64'd0);
    @(negedge clk); reset_active_low = 1'b1;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
